// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : Wait-stated data-memory responder. Accepts one load or store
//            at a time and completes it after WAIT_STATES busy cycles with a
//            one-cycle ready pulse. Out-of-range accesses complete with err.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int WIDTH       = 32,
   parameter int AW          = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             MemRead,
   input  logic             MemWrite,
   output logic [WIDTH-1:0] rdata,
   output logic             ready,
   output logic             busy,
   output logic             err
);

   // Counter only needs to reach WAIT_STATES-1; keep at least one bit.
   localparam int            CW       = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CW-1:0] CNT_LAST = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;
   localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_next;
   logic             enter_done;

   logic [AW-1:0]    addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic             is_write_q;

   logic             req_one;
   logic             req_both;
   logic [AW-1:0]    acc_addr;
   logic [WIDTH-1:0] acc_wdata;
   logic             acc_write;
   logic             acc_in_range;
   logic [IW-1:0]    acc_idx;

   logic [WIDTH-1:0] mem [DEPTH];

   assign req_one  = MemRead ^ MemWrite;
   assign req_both = MemRead & MemWrite;

   // With zero wait states the access completes on the acceptance edge, so
   // the live inputs are used instead of the (not yet loaded) latches.
   always_comb begin
      acc_addr     = addr_q;
      acc_wdata    = wdata_q;
      acc_write    = is_write_q;
      if (state == IDLE) begin
         acc_addr  = addr;
         acc_wdata = wdata;
         acc_write = MemWrite;
      end
      acc_in_range = (int'(acc_addr) < DEPTH);
      acc_idx      = acc_addr[IW-1:0];
   end

   // Next-state and wait counter logic.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      enter_done = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (req_one) begin
               if (WAIT_STATES == 0) begin
                  state_next = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (cnt == CNT_LAST) begin
               state_next = DONE;
               enter_done = 1'b1;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // State, request latches, load data and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         rdata      <= '0;
         err        <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         err   <= ((state == IDLE) && req_both) || (enter_done && !acc_in_range);
         if ((state == IDLE) && req_one) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            is_write_q <= MemWrite;
         end
         if (enter_done && !acc_write) begin
            rdata <= acc_in_range ? mem[acc_idx] : '0;
         end
      end
   end

   // Store commits on DONE entry; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (!reset && enter_done && acc_write && acc_in_range) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign ready = (state == DONE);
   assign busy  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder. Instance A uses
//            DEPTH=128 / WAIT_STATES=2, instance B uses DEPTH=256 /
//            WAIT_STATES=0. Expected values come from an array model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_rd, a_wr, b_rd, b_wr;
   logic [7:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic [31:0] a_rdata, b_rdata;
   logic        a_ready, a_busy, a_err;
   logic        b_ready, b_busy, b_err;

   int checks = 0;
   int errors = 0;

   // Reference model: memory contents per instance and last load result.
   logic [31:0] ref_mem   [2][256];
   bit          known     [2][256];
   logic [31:0] ref_rdata [2];
   bit          rd_known  [2];

   always #5 clk = ~clk;

   dmem_responder #(.WIDTH(32), .AW(8), .DEPTH(128), .WAIT_STATES(2)) dut_a (
      .clk(clk), .reset(reset), .addr(a_addr), .wdata(a_wdata),
      .MemRead(a_rd), .MemWrite(a_wr), .rdata(a_rdata),
      .ready(a_ready), .busy(a_busy), .err(a_err)
   );

   dmem_responder #(.WIDTH(32), .AW(8), .DEPTH(256), .WAIT_STATES(0)) dut_b (
      .clk(clk), .reset(reset), .addr(b_addr), .wdata(b_wdata),
      .MemRead(b_rd), .MemWrite(b_wr), .rdata(b_rdata),
      .ready(b_ready), .busy(b_busy), .err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // sel: 0 rdata, 1 ready, 2 busy, 3 err
   function automatic logic [31:0] get(input int w, input int sel);
      logic [31:0] v;
      case (sel)
         0:       v = w ? b_rdata : a_rdata;
         1:       v = 32'(w ? b_ready : a_ready);
         2:       v = 32'(w ? b_busy : a_busy);
         default: v = 32'(w ? b_err : a_err);
      endcase
      return v;
   endfunction

   task automatic drive(input int w, input logic rd, input logic wr,
                        input logic [7:0] ad, input logic [31:0] d);
      if (w == 0) begin
         a_rd = rd; a_wr = wr; a_addr = ad; a_wdata = d;
      end else begin
         b_rd = rd; b_wr = wr; b_addr = ad; b_wdata = d;
      end
   endtask

   // op: 0 load, 1 store, 2 both (rejected)
   task automatic access(input int w, input int op, input logic [7:0] ad, input logic [31:0] d);
      int          ws        = (w != 0) ? 0 : 2;
      int          depth     = (w != 0) ? 256 : 128;
      bit          oor       = (int'(ad) >= depth);
      logic [31:0] old       = ref_rdata[w];
      bit          old_known = rd_known[w];
      @(negedge clk);
      chk("idle_busy",  get(w, 2), 32'd0);
      chk("idle_ready", get(w, 1), 32'd0);
      chk("idle_err",   get(w, 3), 32'd0);
      drive(w, op != 1, op != 0, ad, d);
      @(posedge clk);
      #1 drive(w, 1'b0, 1'b0, ad, d);
      if (op == 2) begin
         @(negedge clk);
         chk("reject_err",   get(w, 3), 32'd1);
         chk("reject_ready", get(w, 1), 32'd0);
         chk("reject_busy",  get(w, 2), 32'd0);
         return;
      end
      if (op == 1 && !oor) begin
         ref_mem[w][ad] = d;
         known[w][ad]   = 1'b1;
      end
      if (op == 0) begin
         if (oor) begin
            ref_rdata[w] = '0;
            rd_known[w]  = 1'b1;
         end else begin
            ref_rdata[w] = ref_mem[w][ad];
            rd_known[w]  = known[w][ad];
         end
      end
      for (int k = 1; k <= ws + 1; k++) begin
         @(negedge clk);
         chk("acc_busy",  get(w, 2), 32'd1);
         chk("acc_ready", get(w, 1), 32'(k == ws + 1));
         if (k == ws + 1) begin
            chk("done_err", get(w, 3), 32'(oor));
            if (rd_known[w]) chk("done_rdata", get(w, 0), ref_rdata[w]);
         end else if (old_known) begin
            chk("held_rdata", get(w, 0), old);
         end
      end
   endtask

   initial begin
      logic [31:0] exp;
      logic [7:0]  ra;
      int          r;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
      drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 256; i++) begin
         known[0][i] = 1'b0;
         known[1][i] = 1'b0;
         ref_mem[0][i] = '0;
         ref_mem[1][i] = '0;
      end
      ref_rdata[0] = '0; ref_rdata[1] = '0;
      rd_known[0]  = 1'b1; rd_known[1] = 1'b1;

      repeat (3) @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         chk("rst_rdata", get(w, 0), 32'd0);
         chk("rst_ready", get(w, 1), 32'd0);
         chk("rst_busy",  get(w, 2), 32'd0);
         chk("rst_err",   get(w, 3), 32'd0);
      end
      reset = 1'b0;

      // Store, load back, rdata held across later stores.
      access(0, 1, 8'h10, 32'hDEADBEEF);
      access(0, 0, 8'h10, 32'h0);
      access(0, 1, 8'h11, $urandom);
      access(0, 1, 8'h11, $urandom);

      // Rejected request leaves memory untouched.
      access(0, 2, 8'h10, 32'h0BAD0BAD);
      access(0, 0, 8'h10, 32'h0);

      // Out-of-range load/store and aliasing check.
      access(0, 1, 8'h70, 32'h70707070);
      access(0, 0, 8'hF0, 32'h0);
      access(0, 1, 8'hF0, 32'hF0F0F0F0);
      access(0, 0, 8'h70, 32'h0);

      // Reset one cycle after accepting a store aborts it.
      access(0, 1, 8'h20, 32'hCAFE0020);
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 8'h20, 32'h12345678);
      @(posedge clk);
      #1 drive(0, 1'b0, 1'b0, 8'h20, 32'h12345678);
      @(negedge clk);
      chk("pre_rst_busy", get(0, 2), 32'd1);
      reset = 1'b1;
      #1;
      chk("async_rst_busy",  get(0, 2), 32'd0);
      chk("async_rst_ready", get(0, 1), 32'd0);
      chk("async_rst_err",   get(0, 3), 32'd0);
      chk("async_rst_rdata", get(0, 0), 32'd0);
      ref_rdata[0] = '0; ref_rdata[1] = '0;
      @(negedge clk);
      reset = 1'b0;
      access(0, 0, 8'h20, 32'h0);

      // Zero wait states: fill, then MemRead held continuously.
      for (int i = 0; i < 16; i++) access(1, 1, 8'(i), $urandom);
      @(negedge clk);
      b_rd = 1'b1;
      b_wr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ra     = 8'($urandom_range(0, 15));
         b_addr = ra;
         exp    = ref_mem[1][ra];
         @(negedge clk);
         chk("stream_ready", get(1, 1), 32'd1);
         chk("stream_rdata", get(1, 0), exp);
         ref_rdata[1] = exp;
         @(negedge clk);
         chk("stream_gap_ready", get(1, 1), 32'd0);
         if (i == 5) b_rd = 1'b0;
      end
      access(1, 1, 8'h30, 32'h30303030);
      access(1, 0, 8'h30, 32'h0);

      // Randomized mix on both instances.
      repeat (40) begin
         r = int'($urandom_range(0, 9));
         if ($urandom_range(0, 1) == 0)
            access(0, (r < 4) ? 0 : ((r < 8) ? 1 : 2), 8'($urandom_range(0, 255)), $urandom);
         else
            access(1, (r < 4) ? 0 : ((r < 8) ? 1 : 2), 8'($urandom_range(0, 31)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
